axis_packet_arbiter: RTL
========================

# axis_packet_arbiter

Packet-level round-robin arbiter sharing one AXI-Stream master among NUM_SOURCES FIFO-backed requesters. Each requester is a data FIFO plus a control FIFO, written in lockstep, whose control word carries {flag, last, keep}. The arbiter holds a grant for a whole packet, pops both FIFOs of the granted source and presents beats through a 2-entry skid buffer. It sits between the per-source FIFOs and the downstream fifo_to_axis-style consumer or MAC.

## Interface
- NUM_SOURCES, 4: requesters, 2..8.
- DATA_WIDTH, 128: tdata bits, multiple of 8; KEEP_WIDTH = DATA_WIDTH/8; CTRL_WIDTH = KEEP_WIDTH+2.
- STALL_LIMIT, 64: cycles, used only with AXIS_ARB_STALL_TIMEOUT_EN.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- src_empty  in  NUM_SOURCES  per-source FIFO empty; bit i = source i.
- src_data  in  NUM_SOURCES*DATA_WIDTH  first-word-fall-through head data; slice i = [i*DATA_WIDTH +: DATA_WIDTH].
- src_control  in  NUM_SOURCES*CTRL_WIDTH  head control; [CTRL_WIDTH-1] flag, [KEEP_WIDTH] last, [KEEP_WIDTH-1:0] keep.
- src_read_enable  out  NUM_SOURCES  pop strobe, one-hot or zero.
- m_axis_tready  in  1  downstream ready.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tdata  out  DATA_WIDTH  beat data.
- m_axis_tkeep  out  KEEP_WIDTH  byte enables.
- m_axis_tlast  out  1  end of packet.
- m_axis_tdest  out  $clog2(NUM_SOURCES)  source index of the beat.
- grant  out  NUM_SOURCES  one-hot current grant, zero in IDLE.
- stall_error  out  1  sticky timeout flag; constant 0 without macro.

## Operation
- States: IDLE, STREAM.
- IDLE: request vector req = ~src_empty. If req != 0, select first set bit searching from rr_ptr upward with wrap. Register grant, load rr_ptr = winner+1 mod NUM_SOURCES, then enter STREAM. No pop in IDLE.
- STREAM: pop the granted source when !src_empty[g] and skid occupancy < 2, or occupancy == 2 with a transfer this cycle. A pop writes {data, keep, last, g} into the skid buffer.
- Popping a word with last=1 returns the state to IDLE next cycle. The grant is released regardless of skid contents.
- Skid buffer is 2-entry FIFO order. Head drives m_axis_*. The head leaves on tvalid&&tready. tvalid = occupancy != 0.
- Flag bit is not forwarded. keep is forwarded unmodified, including on non-last beats.
- Simultaneous pop and transfer at occupancy 2: both occur, occupancy stays 2.
- Source going empty mid-packet: grant is held, no pop, no bubble filling from other sources.
- Reset mid-packet: the skid buffer is discarded and the partial packet is lost. Source FIFOs are not touched.
- Reset values: state IDLE, rr_ptr 0, grant 0, src_read_enable 0, occupancy 0, m_axis_tvalid 0, m_axis_tdata 0, m_axis_tkeep 0, m_axis_tlast 0, m_axis_tdest 0, stall_error 0.

## Timing
- src_read_enable is combinational from registered state, skid occupancy, src_empty and m_axis_tready. All other outputs are registered.
- Latency, idle to first beat: src_empty[i] falls at cycle 0, grant at cycle 1, pop at cycle 1, m_axis_tvalid at cycle 2.
- Throughput: 1 beat/cycle within a packet while tready=1. Exactly one dead pop cycle (IDLE) between packets.
- Output gap between back-to-back packets: the skid buffer hides it if tready was low at least one cycle; otherwise 1 bubble.

## Configuration
- AXIS_ARB_STALL_TIMEOUT_EN defined:
  - A counter runs in STREAM while src_empty[g]=1. It is cleared on any pop.
  - On reaching STALL_LIMIT: set stall_error (sticky until reset), force state to IDLE, and advance rr_ptr past g.
  - No synthetic tlast is emitted.
- Not defined: no counter, stall_error tied 0, grant held indefinitely.

## Test plan
- Single source 2, one 4-beat packet, tready=1 -> tvalid cycles 2..5, tdest=2, tlast only on beat 4, data equals FIFO order.
- Sources 0,1,3 each hold a 2-beat packet from reset -> packet order 0,1,3, then 0 again when refilled; no interleaving.
- tready toggling 1010 during an 8-beat packet -> no beat lost or duplicated, occupancy never exceeds 2, src_read_enable never asserts with occupancy 2 and tready=0.
- Source 1 empties after beat 2 of 5 while source 0 requests -> no pop from 0 until source 1 delivers last; 0 is granted next.
- Reset asserted on beat 3 of 6 -> next cycle tvalid=0, grant=0; after release the arbiter restarts from rr_ptr 0.
- With AXIS_ARB_STALL_TIMEOUT_EN and STALL_LIMIT=16, source 0 stalls after beat 1 -> stall_error=1 on cycle 16 of the stall, grant moves to the next requester.

Source files
------------

// File: rtl/axis_packet_arbiter.sv
// Packet-level round-robin arbiter: N FIFO requesters onto one AXI-Stream master.
// Optional stall timeout enabled by defining AXIS_ARB_STALL_TIMEOUT_EN.
module axis_packet_arbiter #(
  parameter int NUM_SOURCES = 4,
  parameter int DATA_WIDTH  = 128,
  parameter int STALL_LIMIT = 64,
  localparam int KEEP_WIDTH = DATA_WIDTH / 8,
  localparam int CTRL_WIDTH = KEEP_WIDTH + 2,
  localparam int IDX_WIDTH  = $clog2(NUM_SOURCES)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_SOURCES-1:0]            src_empty,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] src_data,
  input  logic [NUM_SOURCES*CTRL_WIDTH-1:0] src_control,
  output logic [NUM_SOURCES-1:0]            src_read_enable,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]             m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]             m_axis_tkeep,
  output logic                              m_axis_tlast,
  output logic [IDX_WIDTH-1:0]              m_axis_tdest,
  output logic [NUM_SOURCES-1:0]            grant,
  output logic                              stall_error
);

  typedef enum logic {IDLE, STREAM} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
    logic [IDX_WIDTH-1:0]  dest;
  } beat_t;

  localparam logic [IDX_WIDTH:0] NS = (IDX_WIDTH+1)'(NUM_SOURCES);

  state_t state, state_nxt;
  logic [IDX_WIDTH-1:0] rr_ptr, rr_nxt;
  logic [IDX_WIDTH-1:0] gidx, gidx_nxt;
  logic [IDX_WIDTH-1:0] win;
  logic                 win_vld;
  logic [NUM_SOURCES-1:0] grant_nxt;
  logic [IDX_WIDTH:0]   sum;

  beat_t sk0, sk1, in_beat;
  logic [1:0] occ;
  logic pop, xfer, stall_hit;

  function automatic logic [IDX_WIDTH-1:0] inc_mod(
    input logic [IDX_WIDTH-1:0] i
  );
    if (i == IDX_WIDTH'(NUM_SOURCES-1)) return '0;
    return i + 1'b1;
  endfunction

  // Scan from the highest offset down so the nearest requester wins.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    sum     = '0;
    for (int k = NUM_SOURCES-1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (IDX_WIDTH+1)'(k);
      if (sum >= NS) sum = sum - NS;
      if (!src_empty[sum[IDX_WIDTH-1:0]]) begin
        win     = sum[IDX_WIDTH-1:0];
        win_vld = 1'b1;
      end
    end
  end

  assign xfer = (occ != 2'd0) && m_axis_tready;
  assign pop  = (state == STREAM) && !src_empty[gidx]
             && ((occ != 2'd2) || m_axis_tready);

  assign src_read_enable = pop ? grant : '0;

  always_comb begin
    in_beat      = '0;
    in_beat.data = src_data[gidx*DATA_WIDTH +: DATA_WIDTH];
    in_beat.keep = src_control[gidx*CTRL_WIDTH +: KEEP_WIDTH];
    in_beat.last = src_control[gidx*CTRL_WIDTH + KEEP_WIDTH];
    in_beat.dest = gidx;
  end

`ifdef AXIS_ARB_STALL_TIMEOUT_EN
  localparam int SCW = $clog2(STALL_LIMIT + 1);
  logic [SCW-1:0] stall_cnt;
  logic           stall_err_q;

  assign stall_hit = (state == STREAM) && src_empty[gidx]
                  && (stall_cnt == SCW'(STALL_LIMIT - 1));
  assign stall_error = stall_err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt   <= '0;
      stall_err_q <= 1'b0;
    end else begin
      if (state != STREAM || pop || stall_hit) stall_cnt <= '0;
      else if (src_empty[gidx]) stall_cnt <= stall_cnt + 1'b1;
      if (stall_hit) stall_err_q <= 1'b1;
    end
  end
`else
  assign stall_hit   = 1'b0;
  assign stall_error = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    gidx_nxt  = gidx;
    rr_nxt    = rr_ptr;
    unique case (state)
      IDLE: begin
        if (win_vld) begin
          state_nxt      = STREAM;
          grant_nxt      = '0;
          grant_nxt[win] = 1'b1;
          gidx_nxt       = win;
          rr_nxt         = inc_mod(win);
        end
      end
      STREAM: begin
        if (stall_hit) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          rr_nxt    = inc_mod(gidx);
        end else if (pop && in_beat.last) begin
          state_nxt = IDLE;
          grant_nxt = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      grant  <= '0;
      gidx   <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      gidx   <= gidx_nxt;
      rr_ptr <= rr_nxt;
    end
  end

  // Two-entry skid: sk0 is the head presented downstream.
  always_ff @(posedge clock) begin
    if (reset) begin
      occ <= 2'd0;
      sk0 <= '0;
      sk1 <= '0;
    end else begin
      unique case (occ)
        2'd0: begin
          if (pop) begin
            sk0 <= in_beat;
            occ <= 2'd1;
          end
        end
        2'd1: begin
          if (pop && xfer) begin
            sk0 <= in_beat;
          end else if (xfer) begin
            occ <= 2'd0;
          end else if (pop) begin
            sk1 <= in_beat;
            occ <= 2'd2;
          end
        end
        default: begin
          if (xfer) begin
            sk0 <= sk1;
            if (pop) sk1 <= in_beat;
            else     occ <= 2'd1;
          end
        end
      endcase
    end
  end

  assign m_axis_tvalid = (occ != 2'd0);
  assign m_axis_tdata  = sk0.data;
  assign m_axis_tkeep  = sk0.keep;
  assign m_axis_tlast  = sk0.last;
  assign m_axis_tdest  = sk0.dest;

endmodule
